// File: rtl/ahb_fetch_master.sv
`timescale 1ns/1ps
// ahb_fetch_master: AHB-Lite SINGLE/WRAP4 instruction-fetch read initiator assembling a 4-word line.
// Latency: zero-wait SINGLE gives resp_valid 3 cycles after accept, WRAP4 6 cycles; +1 per hready-low cycle.
// Backpressure: hready low freezes all bus state; resp_valid held until resp_ready; req_ready only when idle.
// Optional macro FETCH_CRIT_WORD_EN adds crit_valid/crit_data early forwarding of the requested word.
module ahb_fetch_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_burst,
    output logic [ADDR_W-1:0]   haddr,
    output logic [1:0]          htrans,
    output logic [2:0]          hburst,
    output logic                hwrite,
    input  logic                hready,
    input  logic [DATA_W-1:0]   hrdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [4*DATA_W-1:0] resp_line,
    output logic [3:0]          resp_mask
`ifdef FETCH_CRIT_WORD_EN
    ,
    output logic                crit_valid,
    output logic [DATA_W-1:0]   crit_data
`endif
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [ADDR_W-5:0]   base_q;     // 16-byte aligned line base
    logic [1:0]          off_q;      // word offset of the address currently on the bus
    logic                wrap_q;
    logic [2:0]          issued_q;   // address phases completed in this burst
    logic [DATA_W-1:0]   line_q [4];

    logic [1:0]          off_nxt;
    logic [1:0]          off_prv;
    logic [1:0]          cap_slot;
    logic                cap_en;
    logic                accept;
    logic                unused_addr_bits;

    // Byte-lane bits of the request address carry no information for word fetches.
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_ready && req_valid;
    assign hwrite    = 1'b0;
    assign off_nxt   = off_q + 2'd1;
    assign off_prv   = off_q - 2'd1;

    // The beat returning in BURST belongs to the previous (contiguous, wrapping) address;
    // in DRAIN haddr is held, so the beat belongs to the current offset.
    assign cap_en   = hready && ((state_q == S_BURST) || (state_q == S_DRAIN));
    assign cap_slot = (state_q == S_BURST) ? off_prv : off_q;

    assign resp_line = {line_q[3], line_q[2], line_q[1], line_q[0]};

    // Bus sequencing FSM: address/control outputs registered and frozen while hready is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            off_q      <= 2'd0;
            wrap_q     <= 1'b0;
            issued_q   <= 3'd0;
            haddr      <= '0;
            htrans     <= HTRANS_IDLE;
            hburst     <= HBURST_SINGLE;
            resp_valid <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        base_q   <= req_addr[ADDR_W-1:4];
                        off_q    <= req_addr[3:2];
                        wrap_q   <= req_burst;
                        issued_q <= 3'd0;
                        haddr    <= {req_addr[ADDR_W-1:4], req_addr[3:2], 2'b00};
                        htrans   <= HTRANS_NONSEQ;
                        hburst   <= req_burst ? HBURST_WRAP4 : HBURST_SINGLE;
                        state_q  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        if (wrap_q) begin
                            off_q    <= off_nxt;
                            issued_q <= 3'd1;
                            haddr    <= {base_q, off_nxt, 2'b00};
                            htrans   <= HTRANS_SEQ;
                            state_q  <= S_BURST;
                        end else begin
                            htrans  <= HTRANS_IDLE;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_BURST: begin
                    if (hready) begin
                        issued_q <= issued_q + 3'd1;
                        if (issued_q == 3'd3) begin
                            htrans  <= HTRANS_IDLE;
                            state_q <= S_DRAIN;
                        end else begin
                            off_q <= off_nxt;
                            haddr <= {base_q, off_nxt, 2'b00};
                        end
                    end
                end
                S_DRAIN: begin
                    if (hready) begin
                        resp_valid <= 1'b1;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CRIT_WORD_EN
    logic first_q;   // next captured beat is the requested (critical) word

    // Critical-word forward: one-cycle pulse after the first beat lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_q    <= 1'b0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= cap_en && first_q;
            if (accept) begin
                first_q <= 1'b1;
            end else if (cap_en) begin
                first_q <= 1'b0;
            end
            if (cap_en && first_q) begin
                crit_data <= hrdata;
            end
        end
    end
`endif

    // Line assembly: cleared on accept, each beat lands in the slot of its address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 4; k++) begin
                line_q[k] <= '0;
            end
            resp_mask <= 4'h0;
        end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
                line_q[k] <= '0;
            end
            resp_mask <= 4'h0;
        end else if (cap_en) begin
            line_q[cap_slot]    <= hrdata;
            resp_mask[cap_slot] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_fetch_master.sv
`timescale 1ns/1ps
// tb_ahb_fetch_master: directed stimulus with queued expectations for bus beats and returned lines.
// Latency: checks the issue-to-resp_valid cycle count of every request.
// Backpressure: drives hready stalls and resp_ready holds from the stimulus process.
module tb_ahb_fetch_master;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_burst;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hwrite;
    logic          hready = 1'b1;
    logic [31:0]   hrdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [127:0]  resp_line;
    logic [3:0]    resp_mask;
`ifdef FETCH_CRIT_WORD_EN
    logic          crit_valid;
    logic [31:0]   crit_data;
`endif

    ahb_fetch_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_burst  (req_burst),
        .haddr      (haddr),
        .htrans     (htrans),
        .hburst     (hburst),
        .hwrite     (hwrite),
        .hready     (hready),
        .hrdata     (hrdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_line  (resp_line),
        .resp_mask  (resp_mask)
`ifdef FETCH_CRIT_WORD_EN
        ,
        .crit_valid (crit_valid),
        .crit_data  (crit_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
        logic [2:0]  b;
    } bus_t;

    typedef struct packed {
        logic [127:0] line;
        logic [3:0]   mask;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] beat_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event not seen within bound", nm);
    endtask

    function automatic logic [127:0] mkline(input logic [31:0] w3, input logic [31:0] w2,
                                            input logic [31:0] w1, input logic [31:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    task automatic push_bus(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b);
        bus_t e;
        e.a = a; e.t = t; e.b = b;
        bus_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [127:0] line, input logic [3:0] mask);
        rsp_t e;
        e.line = line; e.mask = mask;
        rsp_q.push_back(e);
    endtask

    // hready stall window, in absolute cycle numbers
    int stall_lo = 1000000;
    int stall_hi = 0;
    always @(posedge clk) begin
        #1;
        hready = !(cyc >= stall_lo && cyc <= stall_hi);
    end

    // Slave data model plus bus/response monitors, all evaluated mid-cycle.
    logic dphase = 1'b0;
    logic p_hready = 1'b0;
    logic p_trans = 1'b0;
    always @(negedge clk) begin
        bus_t be;
        rsp_t re;
        if (!rstn) begin
            dphase   = 1'b0;
            p_hready = 1'b0;
            p_trans  = 1'b0;
            hrdata   = 32'h0;
        end else begin
            if (p_hready) begin
                if (dphase && beat_q.size() > 0) void'(beat_q.pop_front());
                dphase = p_trans;
            end
            hrdata   = (dphase && beat_q.size() > 0) ? beat_q[0] : 32'h0;
            p_hready = hready;
            p_trans  = htrans[1];

            if (hready && htrans != 2'b00) begin
                if (bus_q.size() == 0) begin
                    fail_now("bus_unexpected_beat");
                end else begin
                    be = bus_q.pop_front();
                    chk("haddr", haddr, be.a);
                    chk("htrans", htrans, be.t);
                    chk("hburst", hburst, be.b);
                    chk("hwrite", hwrite, 1'b0);
                end
            end
            if (resp_valid && resp_ready) begin
                if (rsp_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    re = rsp_q.pop_front();
                    chk("resp_line", resp_line, re.line);
                    chk("resp_mask", resp_mask, re.mask);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic burst, output int t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_burst = burst;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail_now("req_accept");
        t = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int t, input int lat, input string nm);
        int n;
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (resp_valid) seen = 1;
        end
        if (!seen) fail_now(nm);
        else chk(nm, cyc - t, lat);
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_htrans"}, htrans, 2'b00);
        chk({tag, "_haddr"}, haddr, 32'h0);
        chk({tag, "_hburst"}, hburst, 3'b000);
        chk({tag, "_hwrite"}, hwrite, 1'b0);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_line"}, resp_line, 128'h0);
        chk({tag, "_resp_mask"}, resp_mask, 4'h0);
    endtask

    initial begin
        int t;
        int t2;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_burst  = 1'b0;
        resp_ready = 1'b1;
        hrdata     = 32'h0;
        #2;
        chk_reset_vals("rst");
`ifdef FETCH_CRIT_WORD_EN
        chk("rst_crit_valid", crit_valid, 1'b0);
        chk("rst_crit_data", crit_data, 32'h0);
`endif
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // SINGLE at 0x1008
        push_bus(32'h1008, 2'b10, 3'b000);
        beat_q.push_back(32'hA5A5_0001);
        push_rsp(mkline(32'h0, 32'hA5A5_0001, 32'h0, 32'h0), 4'b0100);
        issue(32'h1008, 1'b0, t);
        wait_resp(t, 3, "single_latency");

        // WRAP4 at 0x2004: 0x2004, 0x2008, 0x200C, 0x2000
        push_bus(32'h2004, 2'b10, 3'b010);
        push_bus(32'h2008, 2'b11, 3'b010);
        push_bus(32'h200C, 2'b11, 3'b010);
        push_bus(32'h2000, 2'b11, 3'b010);
        beat_q.push_back(32'h1111_0001);
        beat_q.push_back(32'h2222_0002);
        beat_q.push_back(32'h3333_0003);
        beat_q.push_back(32'h4444_0000);
        push_rsp(mkline(32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h4444_0000), 4'hF);
        issue(32'h2004, 1'b1, t);
        wait_resp(t, 6, "wrap4_latency");

        // WRAP4 at 0x300C with hready low during the second SEQ
        push_bus(32'h300C, 2'b10, 3'b010);
        push_bus(32'h3000, 2'b11, 3'b010);
        push_bus(32'h3004, 2'b11, 3'b010);
        push_bus(32'h3008, 2'b11, 3'b010);
        beat_q.push_back(32'hC0DE_0003);
        beat_q.push_back(32'hC0DE_0000);
        beat_q.push_back(32'hC0DE_0001);
        beat_q.push_back(32'hC0DE_0002);
        push_rsp(mkline(32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000), 4'hF);
        stall_lo = cyc + 3;
        stall_hi = cyc + 4;
        issue(32'h300C, 1'b1, t);
        @(negedge clk);           // T+1
        @(negedge clk);           // T+2
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);       // T+3, T+4: stalled second SEQ
            chk("stall_haddr", haddr, 32'h3004);
            chk("stall_htrans", htrans, 2'b11);
            chk("stall_resp_mask", resp_mask, 4'b1000);
        end
        wait_resp(t, 8, "stall_latency");
        stall_lo = 1000000;
        stall_hi = 0;

        // SINGLE at 0x100C with resp_ready held low 3 cycles; a second request waits
        push_bus(32'h100C, 2'b10, 3'b000);
        beat_q.push_back(32'h0BAD_F00D);
        push_rsp(mkline(32'h0BAD_F00D, 32'h0, 32'h0, 32'h0), 4'b1000);
        push_bus(32'h1004, 2'b10, 3'b000);
        beat_q.push_back(32'h7777_1111);
        push_rsp(mkline(32'h0, 32'h0, 32'h7777_1111, 32'h0), 4'b0010);
        resp_ready = 1'b0;
        issue(32'h100C, 1'b0, t);
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (resp_valid) seen = 1;
            end
            if (!seen) fail_now("hold_resp_valid");
            else chk("hold_latency", cyc - t, 3);
        end
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h1004;
        req_burst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_resp_valid", resp_valid, 1'b1);
            chk("hold_resp_line", resp_line, mkline(32'h0BAD_F00D, 32'h0, 32'h0, 32'h0));
            chk("hold_req_ready", req_ready, 1'b0);
            chk("hold_htrans", htrans, 2'b00);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);           // handshake cycle
        chk("hs_req_ready", req_ready, 1'b0);
        tick();
        chk("post_hs_req_ready", req_ready, 1'b1);
        t2 = cyc;
        tick();
        req_valid = 1'b0;
        wait_resp(t2, 3, "after_hold_latency");

        // Reset pulsed during the third beat of a WRAP4
        push_bus(32'h5000, 2'b10, 3'b010);
        push_bus(32'h5004, 2'b11, 3'b010);
        push_bus(32'h5008, 2'b11, 3'b010);
        for (int i = 0; i < 4; i++) beat_q.push_back(32'h5555_0000 + i);
        issue(32'h5000, 1'b1, t);
        tick();
        tick();
        tick();                   // T+4
        rstn = 1'b0;
        beat_q.delete();
        #1;
        chk_reset_vals("midrst");
        chk("midrst_bus_pending", bus_q.size(), 0);
        tick();
        rstn = 1'b1;
        tick();

        push_bus(32'h6008, 2'b10, 3'b000);
        beat_q.push_back(32'h6666_0002);
        push_rsp(mkline(32'h0, 32'h6666_0002, 32'h0, 32'h0), 4'b0100);
        issue(32'h6008, 1'b0, t);
        wait_resp(t, 3, "post_reset_latency");

`ifdef FETCH_CRIT_WORD_EN
        // Critical-word forward on WRAP4 at 0x4008
        push_bus(32'h4008, 2'b10, 3'b010);
        push_bus(32'h400C, 2'b11, 3'b010);
        push_bus(32'h4000, 2'b11, 3'b010);
        push_bus(32'h4004, 2'b11, 3'b010);
        beat_q.push_back(32'h1234_5678);
        beat_q.push_back(32'h0000_00CC);
        beat_q.push_back(32'h0000_00AA);
        beat_q.push_back(32'h0000_00BB);
        push_rsp(mkline(32'h0000_00CC, 32'h1234_5678, 32'h0000_00BB, 32'h0000_00AA), 4'hF);
        issue(32'h4008, 1'b1, t);
        @(negedge clk);           // T+1
        chk("crit_t1", crit_valid, 1'b0);
        @(negedge clk);           // T+2
        chk("crit_t2", crit_valid, 1'b0);
        @(negedge clk);           // T+3
        chk("crit_t3_valid", crit_valid, 1'b1);
        chk("crit_t3_data", crit_data, 32'h1234_5678);
        @(negedge clk);           // T+4
        chk("crit_t4", crit_valid, 1'b0);
        wait_resp(t, 6, "crit_wrap4_latency");
`endif

        repeat (3) tick();
        chk("bus_q_empty", bus_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_fetch_master.md
# ahb_fetch_master

AHB-Lite read initiator that issues the instruction-fetch transfers consumed by the I-cache transfer handler. Accepts one fetch request at a time from the fetch unit, drives a SINGLE or WRAP4 read burst (NONSEQ then SEQ, 4-word wrapping boundary) with correct `hready` stall handling, and collects the returned beats into a 4-word line. Returns the assembled line to the requester through a valid/ready response handshake.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data bus width; one beat = one word, byte address step 4

- `clk`  in  1  clock; all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  fetch request present
- `req_ready`  out  1  block idle, request accepted when `req_valid && req_ready`
- `req_addr`  in  ADDR_W  byte address of critical word; bits [1:0] ignored
- `req_burst`  in  1  0 = SINGLE, 1 = WRAP4
- `haddr`  out  ADDR_W  AHB address
- `htrans`  out  2  IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11 (BUSY never driven)
- `hburst`  out  3  SINGLE=3'b000, WRAP4=3'b010
- `hwrite`  out  1  constant 0
- `hready`  in  1  slave ready; gates both address and data phase
- `hrdata`  in  DATA_W  read data
- `resp_valid`  out  1  line available; held until accepted
- `resp_ready`  in  1  requester accepts line
- `resp_line`  out  4*DATA_W  word k at bits [k*DATA_W +: DATA_W], k = address bits [3:2]
- `resp_mask`  out  4  valid words: one-hot for SINGLE, 4'hF for WRAP4

## Operation
- States: IDLE, ADDR (NONSEQ phase), BURST (SEQ phases, overlapping data), DRAIN (last data phase, `htrans`=IDLE), RESP.
- IDLE: `req_ready`=1. Accept -> latch base = `req_addr & ~32'hF`, offset = `req_addr[3:2]`, burst type; clear `resp_line`/`resp_mask`; go ADDR.
- ADDR: `htrans`=NONSEQ, `haddr`=base|offset<<2, `hburst` per type. On `hready`: SINGLE -> DRAIN; WRAP4 -> BURST, offset = (offset+1) mod 4, issued count = 1.
- BURST: `htrans`=SEQ, `haddr`=base|offset<<2. On `hready`: capture data beat of previous address phase; if 4 addresses issued after this one -> DRAIN, else advance offset mod 4 (wraps 3->0 within 16-byte boundary).
- DRAIN: `htrans`=IDLE, `hburst`/`haddr` hold last values. On `hready`: capture final beat -> RESP.
- Capture: `hrdata` written to word slot of the corresponding address; `resp_mask` bit set.
- RESP: `resp_valid`=1; on `resp_ready` -> IDLE. `resp_line`/`resp_mask` stable while `resp_valid`.
- `hready` low: all address/control outputs and counters hold; no capture.
- Beat counters 3 bits; offset arithmetic 2 bits, natural wrap.
- New request while busy: not accepted (`req_ready`=0); no queueing.

## Timing
- Reset values: `req_ready`=1, `htrans`=IDLE, `haddr`=0, `hburst`=SINGLE, `hwrite`=0, `resp_valid`=0, `resp_line`=0, `resp_mask`=0; state IDLE.
- All outputs registered except `req_ready` (decode of IDLE state).
- Zero-wait latency, accept at cycle T: NONSEQ in T+1; SINGLE data sampled end of T+2, `resp_valid` T+3. WRAP4 SEQ T+2..T+4, data sampled end of T+2..T+5, `resp_valid` T+6.
- Each `hready`-low cycle adds exactly one cycle of latency.
- `req_ready` reasserts the cycle after the `resp_valid && resp_ready` handshake (no same-cycle bypass).
- Reset asserted mid-burst: all outputs return to reset values immediately; partial line discarded.

## Configuration
- `FETCH_CRIT_WORD_EN` defined: extra ports `crit_valid` (out, 1) and `crit_data` (out, DATA_W); `crit_valid` pulses one cycle, the cycle after the first beat (requested word) is captured, `crit_data` holds that word until the next capture. Reset: 0/0.
- Undefined: ports absent; line delivered only through `resp_*`.

## Test plan
- SINGLE, `req_addr`=0x1008, `hready`=1, `hrdata`=0xA5A5_0001 -> NONSEQ@0x1008, `hburst`=000, `resp_valid` at T+3, `resp_mask`=4'b0100, word 2 = 0xA5A5_0001.
- WRAP4, `req_addr`=0x2004 -> `haddr` 0x2004, 0x2008, 0x200C, 0x2000 with NONSEQ,SEQ,SEQ,SEQ; `resp_mask`=4'hF, words placed by address; `resp_valid` at T+6.
- WRAP4 `req_addr`=0x300C with `hready` low 2 cycles during second SEQ -> address/control held, no extra capture, `resp_valid` at T+8.
- `resp_ready` low 3 cycles -> `resp_valid`/`resp_line` stable, `req_ready`=0; new `req_valid` ignored until cycle after handshake.
- `rstn` pulsed low during third beat of WRAP4 -> all outputs at reset values; subsequent SINGLE completes normally.
- `FETCH_CRIT_WORD_EN` build, WRAP4 at 0x4008, first `hrdata`=0x1234_5678 -> one-cycle `crit_valid` at T+3 with `crit_data`=0x1234_5678.
